// File: rtl/segment7_pkg.sv
// Shared constants and types for the binary-to-BCD converter
// and the seven-segment display driver.
package segment7_pkg;

    localparam int BIN_W      = 14;
    localparam int BCD_DIGITS = 4;
    localparam int DIG_W      = 4;
    localparam int BCD_W      = BCD_DIGITS * DIG_W;
    localparam int SHIFT_CNT  = 14;
    localparam int CNT_W      = 4;

    localparam logic [BIN_W-1:0] BCD_MAX = 14'd9999;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

endpackage

// File: rtl/binary_to_bcd_if.sv
// Request/result bundle between a converter client and binary_to_bcd.
// Master drives the operand and strobe; slave returns status and digits.
interface binary_to_bcd_if;
    import segment7_pkg::*;

    logic [BIN_W-1:0] BIN;
    logic             START;
    logic             BUSY;
    logic             DONE;
    logic             OVF;
    logic [DIG_W-1:0] D1;
    logic [DIG_W-1:0] D2;
    logic [DIG_W-1:0] D3;
    logic [DIG_W-1:0] D4;

    modport master (
        output BIN, START,
        input  BUSY, DONE, OVF, D1, D2, D3, D4
    );

    modport slave (
        input  BIN, START,
        output BUSY, DONE, OVF, D1, D2, D3, D4
    );

endinterface

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: add 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next digit.
module bcd_add3 (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);

    assign o_nib = (i_nib >= 4'd5) ? i_nib + 4'd3 : i_nib;

endmodule

// File: rtl/binary_to_bcd.sv
// Iterative 14-bit binary to 4-digit BCD converter (shift-add-3).
// Optional macro BINARY_TO_BCD_SAT_EN clamps operands above 9999 to 9999.
import segment7_pkg::*;

module binary_to_bcd (
    input logic            CLK,
    input logic            CLR,
    binary_to_bcd_if.slave bus
);

    state_t             r_state;
    state_t             w_next_state;
    logic [BIN_W-1:0]   r_operand;
    logic [BIN_W-1:0]   w_latch;
    logic [BCD_W-1:0]   r_scratch;
    logic [BCD_W-1:0]   w_corr;
    logic [BCD_W:0]     w_shift;
    logic [CNT_W-1:0]   r_cnt;
    logic [BCD_W-1:0]   r_digits;
    logic               r_ovf_pend;
    logic               r_ovf;
    logic               r_done;
    logic               w_accept;
    logic               w_last;
    logic               w_too_big;

    assign w_too_big = (bus.BIN > BCD_MAX);

`ifdef BINARY_TO_BCD_SAT_EN
    assign w_latch = w_too_big ? BCD_MAX : bus.BIN;
`else
    assign w_latch = bus.BIN;
`endif

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .i_nib (r_scratch[g*DIG_W +: DIG_W]),
            .o_nib (w_corr[g*DIG_W +: DIG_W])
        );
    end

    // The ten-thousands bit can only become set on the final shift
    // (the partial value is below 10000 before it), so it lives only
    // here as w_shift[BCD_W] and is never corrected.
    assign w_shift  = {w_corr, r_operand[BIN_W-1]};
    assign w_accept = (r_state == IDLE) && bus.START;
    assign w_last   = (r_state == SHIFT) && (r_cnt == CNT_W'(1));

    // State register; clear wins over any pending start.
    always_ff @(posedge CLK) begin
        if (CLR) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state: one accepted start, then fourteen shifts.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (bus.START) w_next_state = SHIFT;
            SHIFT:   if (w_last)    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Busy is simply "inside a conversion".
    always_comb begin
        bus.BUSY = (r_state == SHIFT);
    end

    // Datapath: latch, shift-add-3, then publish digits with a done pulse.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_operand  <= '0;
            r_scratch  <= '0;
            r_cnt      <= '0;
            r_digits   <= '0;
            r_ovf_pend <= 1'b0;
            r_ovf      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_operand  <= w_latch;
                r_scratch  <= '0;
                r_cnt      <= CNT_W'(SHIFT_CNT);
                r_ovf_pend <= w_too_big;
            end else if (r_state == SHIFT) begin
                r_scratch <= w_shift[BCD_W-1:0];
                r_operand <= r_operand << 1;
                r_cnt     <= r_cnt - CNT_W'(1);
                if (w_last) begin
                    r_digits <= w_shift[BCD_W-1:0];
                    r_ovf    <= r_ovf_pend | w_shift[BCD_W];
                    r_done   <= 1'b1;
                end
            end
        end
    end

    assign bus.DONE = r_done;
    assign bus.OVF  = r_ovf;
    assign bus.D1   = r_digits[0*DIG_W +: DIG_W];
    assign bus.D2   = r_digits[1*DIG_W +: DIG_W];
    assign bus.D3   = r_digits[2*DIG_W +: DIG_W];
    assign bus.D4   = r_digits[3*DIG_W +: DIG_W];

endmodule

// File: tb/tb_binary_to_bcd.sv
// Directed testbench for binary_to_bcd.
// Expected digits for operands above 9999 depend on BINARY_TO_BCD_SAT_EN.
module tb_binary_to_bcd;

    logic clk;
    logic clr;
    int   tests;
    int   fails;

    binary_to_bcd_if bus ();

    binary_to_bcd dut (
        .CLK (clk),
        .CLR (clr),
        .bus (bus)
    );

    logic [15:0] digits;
    assign digits = {bus.D4, bus.D3, bus.D2, bus.D1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents BIN with START for one edge (the accepting edge k).
    task automatic start_conv(input logic [13:0] v);
        bus.BIN   = v;
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
    endtask

    // Returns edges after k until DONE is seen, or -1 if it never comes.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (bus.DONE !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        if (bus.DONE !== 1'b1) cyc = -1;
    endtask

    task automatic test_reset();
        clr       = 1'b1;
        bus.START = 1'b0;
        bus.BIN   = '0;
        tick();
        tick();
        clr = 1'b0;
        tests++;
        if (bus.BUSY !== 1'b0) begin
            fails++;
            $display("FAIL reset_busy: got %b want 0", bus.BUSY);
        end
        tests++;
        if (bus.DONE !== 1'b0 || bus.OVF !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags: done %b ovf %b want 0 0",
                     bus.DONE, bus.OVF);
        end
        tests++;
        if (digits !== 16'h0000) begin
            fails++;
            $display("FAIL reset_digits: got %h want 0000", digits);
        end
    endtask

    task automatic test_zero();
        int cyc;
        start_conv(14'd0);
        wait_done(cyc);
        tests++;
        if (cyc != 14) begin
            fails++;
            $display("FAIL zero_latency: got %0d want 14", cyc);
        end
        tests++;
        if (digits !== 16'h0000 || bus.OVF !== 1'b0) begin
            fails++;
            $display("FAIL zero_result: got %h ovf %b want 0000 0",
                     digits, bus.OVF);
        end
    endtask

    task automatic test_timing_1234();
        int busy_cnt;
        int early;
        busy_cnt = 0;
        early    = 0;
        start_conv(14'd1234);
        for (int i = 0; i < 14; i++) begin
            if (bus.BUSY === 1'b1) busy_cnt++;
            if (bus.DONE !== 1'b0) early++;
            tick();
        end
        tests++;
        if (busy_cnt != 14 || early != 0) begin
            fails++;
            $display("FAIL busy_window: busy %0d early_done %0d want 14 0",
                     busy_cnt, early);
        end
        tests++;
        if (bus.DONE !== 1'b1 || bus.BUSY !== 1'b0) begin
            fails++;
            $display("FAIL done_cycle: done %b busy %b want 1 0",
                     bus.DONE, bus.BUSY);
        end
        tests++;
        if (digits !== 16'h1234 || bus.OVF !== 1'b0) begin
            fails++;
            $display("FAIL conv_1234: got %h ovf %b want 1234 0",
                     digits, bus.OVF);
        end
        tick();
        tests++;
        if (bus.DONE !== 1'b0) begin
            fails++;
            $display("FAIL done_pulse: got %b want 0", bus.DONE);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int bad;
        bad = 0;
        start_conv(14'd9999);
        wait_done(cyc);
        tests++;
        if (cyc != 14 || digits !== 16'h9999 || bus.OVF !== 1'b0) begin
            fails++;
            $display("FAIL conv_9999: cyc %0d got %h ovf %b want 14 9999 0",
                     cyc, digits, bus.OVF);
        end
        start_conv(14'd42);
        for (int i = 0; i < 14; i++) begin
            if (digits !== 16'h9999 || bus.DONE !== 1'b0) bad++;
            tick();
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL hold_prev: got %0d bad cycles want 0", bad);
        end
        tests++;
        if (bus.DONE !== 1'b1 || digits !== 16'h0042) begin
            fails++;
            $display("FAIL b2b_0042: done %b got %h want 1 0042",
                     bus.DONE, digits);
        end
    endtask

    task automatic test_overflow();
        int cyc;
        logic [15:0] exp_max;
        logic [15:0] exp_10k;
`ifdef BINARY_TO_BCD_SAT_EN
        exp_max = 16'h9999;
        exp_10k = 16'h9999;
`else
        exp_max = 16'h6383;
        exp_10k = 16'h0000;
`endif
        start_conv(14'd16383);
        wait_done(cyc);
        tests++;
        if (cyc != 14 || digits !== exp_max || bus.OVF !== 1'b1) begin
            fails++;
            $display("FAIL ovf_16383: cyc %0d got %h ovf %b want 14 %h 1",
                     cyc, digits, bus.OVF, exp_max);
        end
        tick();
        start_conv(14'd10000);
        wait_done(cyc);
        tests++;
        if (cyc != 14 || digits !== exp_10k || bus.OVF !== 1'b1) begin
            fails++;
            $display("FAIL ovf_10000: cyc %0d got %h ovf %b want 14 %h 1",
                     cyc, digits, bus.OVF, exp_10k);
        end
        tick();
        start_conv(14'd9998);
        wait_done(cyc);
        tests++;
        if (digits !== 16'h9998 || bus.OVF !== 1'b0) begin
            fails++;
            $display("FAIL ovf_clear: got %h ovf %b want 9998 0",
                     digits, bus.OVF);
        end
        tick();
    endtask

    task automatic test_busy_ignore();
        int dones;
        dones = 0;
        start_conv(14'd777);
        for (int i = 0; i < 14; i++) begin
            bus.BIN   = 14'd5555;
            bus.START = (i % 2 == 1);
            if (bus.DONE === 1'b1) dones++;
            tick();
        end
        bus.START = 1'b0;
        tests++;
        if (bus.DONE !== 1'b1 || digits !== 16'h0777) begin
            fails++;
            $display("FAIL busy_ignore: done %b got %h want 1 0777",
                     bus.DONE, digits);
        end
        for (int i = 0; i < 20; i++) begin
            if (bus.DONE === 1'b1) dones++;
            tick();
        end
        tests++;
        if (dones != 1 || digits !== 16'h0777) begin
            fails++;
            $display("FAIL single_done: got %0d dones %h want 1 0777",
                     dones, digits);
        end
    endtask

    task automatic test_clr_abort();
        int cyc;
        int dones;
        dones = 0;
        start_conv(14'd4321);
        repeat (6) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tests++;
        if (bus.BUSY !== 1'b0 || digits !== 16'h0000 ||
            bus.DONE !== 1'b0 || bus.OVF !== 1'b0) begin
            fails++;
            $display("FAIL clr_abort: busy %b done %b got %h want 0 0 0000",
                     bus.BUSY, bus.DONE, digits);
        end
        for (int i = 0; i < 20; i++) begin
            if (bus.DONE === 1'b1) dones++;
            tick();
        end
        tests++;
        if (dones != 0) begin
            fails++;
            $display("FAIL clr_no_done: got %0d want 0", dones);
        end
        start_conv(14'd321);
        wait_done(cyc);
        tests++;
        if (cyc != 14 || digits !== 16'h0321) begin
            fails++;
            $display("FAIL after_clr: cyc %0d got %h want 14 0321",
                     cyc, digits);
        end
        tick();
    endtask

    task automatic test_clr_start();
        int dones;
        dones = 0;
        bus.BIN   = 14'd1111;
        bus.START = 1'b1;
        clr       = 1'b1;
        tick();
        bus.START = 1'b0;
        clr       = 1'b0;
        tests++;
        if (bus.BUSY !== 1'b0 || digits !== 16'h0000) begin
            fails++;
            $display("FAIL clr_start: busy %b got %h want 0 0000",
                     bus.BUSY, digits);
        end
        for (int i = 0; i < 20; i++) begin
            if (bus.DONE === 1'b1) dones++;
            tick();
        end
        tests++;
        if (dones != 0) begin
            fails++;
            $display("FAIL clr_start_done: got %0d want 0", dones);
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        clr       = 1'b1;
        bus.BIN   = '0;
        bus.START = 1'b0;
        test_reset();
        test_zero();
        tick();
        test_timing_1234();
        test_back_to_back();
        tick();
        test_overflow();
        test_busy_ignore();
        test_clr_abort();
        test_clr_start();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
